// File: rtl/fpnew_lane_sequencer.sv
// fpnew_lane_sequencer: runs a packed SIMD FP op one lane at a time through a single scalar lane unit
// Ports: clk_i/rst_ni (sync active-low), flush_i aborts the op and is echoed on lane_flush_o.
//   in_*    : upstream op (operands, vectorial, mask, tag) with valid/ready.
//   lane_*_o: per-lane issue (operands, mask, valid) plus result-side ready.
//   lane_*_i: lane unit ready, result, status, ext bit, valid.
//   result_o/status_o/extension_bit_o/tag_o/out_valid_o/out_ready_i: reassembled result; busy_o = op held.
module fpnew_lane_sequencer #(
  parameter int unsigned Width       = 64,
  parameter int unsigned FpWidth     = 16,
  parameter int unsigned NumOperands = 3,
  parameter int unsigned TagWidth    = 1,
  localparam int unsigned NumLanes   = Width / FpWidth
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic [NumOperands*Width-1:0]   in_operands_i,
  input  logic                           in_vectorial_i,
  input  logic [NumLanes-1:0]            in_mask_i,
  input  logic [TagWidth-1:0]            in_tag_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  output logic [NumOperands*FpWidth-1:0] lane_operands_o,
  output logic                           lane_mask_o,
  output logic                           lane_valid_o,
  input  logic                           lane_ready_i,
  output logic                           lane_flush_o,
  input  logic [FpWidth-1:0]             lane_result_i,
  input  logic [4:0]                     lane_status_i,
  input  logic                           lane_ext_bit_i,
  input  logic                           lane_valid_i,
  output logic                           lane_ready_o,
  output logic [Width-1:0]               result_o,
  output logic [4:0]                     status_o,
  output logic                           extension_bit_o,
  output logic [TagWidth-1:0]            tag_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic                           busy_o
);
  localparam int unsigned CW = $clog2(NumLanes + 1);
  localparam int unsigned LW = NumLanes > 1 ? $clog2(NumLanes) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e                       state_q, state_d;
  logic [NumOperands*Width-1:0] ops_q, ops_d;
  logic                         vec_q, vec_d;
  logic [NumLanes-1:0]          mask_q, mask_d;
  logic [TagWidth-1:0]          tag_q, tag_d;
  logic [CW-1:0]                iss_q, iss_d, ret_q, ret_d, n;
  logic [Width-1:0]             res_q, res_d;
  logic [4:0]                   st_q, st_d;
  logic                         ext_q, ext_d;
  logic [LW-1:0]                iss_sel, ret_sel;
  logic                         live, accept, ret_fire;
  // Handshakes are suppressed on flush and reset cycles so nothing is half-accepted.
  assign live         = rst_ni & ~flush_i;
  assign n            = vec_q ? CW'(NumLanes) : CW'(1);
  assign iss_sel      = iss_q[LW-1:0];
  assign ret_sel      = ret_q[LW-1:0];
  assign lane_valid_o = live & (state_q == RUN) & (iss_q < n);
  assign lane_ready_o = live & (state_q == RUN);
  assign in_ready_o   = live & ((state_q == IDLE) | ((state_q == DONE) & out_ready_i));
  assign accept       = in_valid_i & in_ready_o;
  assign ret_fire     = lane_ready_o & lane_valid_i & (ret_q < n);
  assign lane_flush_o = flush_i;
  assign lane_mask_o  = mask_q[iss_sel];
  assign out_valid_o  = state_q == DONE;
  assign busy_o       = state_q != IDLE;
  assign status_o     = st_q;
  assign extension_bit_o = ext_q;
  assign tag_o        = tag_q;
  always_comb begin
    lane_operands_o = '0;
    for (int j = 0; j < NumOperands; j++)
      lane_operands_o[j*FpWidth +: FpWidth] = ops_q[j*Width + iss_sel*FpWidth +: FpWidth];
  end
  // Scalar ops NaN-box / sign-extend the upper slots with the lane-0 ext bit.
  for (genvar g = 0; g < NumLanes; g++) begin : g_slot
    assign result_o[g*FpWidth +: FpWidth] = (g == 0 || vec_q) ? res_q[g*FpWidth +: FpWidth] : {FpWidth{ext_q}};
  end
  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    tag_d   = tag_q;
    iss_d   = iss_q;
    ret_d   = ret_q;
    res_d   = res_q;
    st_d    = st_q;
    ext_d   = ext_q;
    if (lane_valid_o && lane_ready_i) iss_d = iss_q + CW'(1);
    if (ret_fire) begin
      res_d[ret_sel*FpWidth +: FpWidth] = lane_result_i;
      st_d  = mask_q[ret_sel] ? st_q | lane_status_i : st_q;
      ext_d = ret_q == '0 ? lane_ext_bit_i : ext_q;
      ret_d = ret_q + CW'(1);
      state_d = ret_q == n - CW'(1) ? DONE : state_q;
    end
    if (state_q == DONE && out_ready_i) state_d = IDLE;
    if (accept) begin
      state_d = RUN;
      ops_d   = in_operands_i;
      vec_d   = in_vectorial_i;
      mask_d  = in_mask_i;
      tag_d   = in_tag_i;
      iss_d   = '0;
      ret_d   = '0;
      st_d    = '0;
      ext_d   = 1'b0;
    end
    if (flush_i) begin
      state_d = IDLE;
      iss_d   = '0;
      ret_d   = '0;
      res_d   = '0;
      st_d    = '0;
      ext_d   = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ops_q   <= '0;
      vec_q   <= 1'b0;
      mask_q  <= '0;
      tag_q   <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
      res_q   <= '0;
      st_q    <= '0;
      ext_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      tag_q   <= tag_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      res_q   <= res_d;
      st_q    <= st_d;
      ext_q   <= ext_d;
    end
  end
  a_lane_ret: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
    lane_valid_i |-> (lane_ready_o && ret_q < n));
endmodule

// File: tb/tb_fpnew_lane_sequencer.sv
// tb_fpnew_lane_sequencer: directed scoreboard bench with a 1-cycle lane unit model
module tb_fpnew_lane_sequencer;
  logic clk_i = 1'b0;
  logic rst_ni, flush_i, in_vectorial_i, in_valid_i, in_ready_o;
  logic [191:0] in_operands_i;
  logic [3:0] in_mask_i;
  logic [0:0] in_tag_i, tag_o;
  logic [47:0] lane_operands_o;
  logic lane_mask_o, lane_valid_o, lane_ready_i, lane_flush_o, lane_ext_bit_i, lane_valid_i, lane_ready_o;
  logic [15:0] lane_result_i;
  logic [4:0] lane_status_i, status_o;
  logic [63:0] result_o;
  logic extension_bit_o, out_valid_o, out_ready_i, busy_o;
  typedef struct {logic [63:0] r; logic [4:0] s; logic e; logic [0:0] t;} exp_t;
  typedef struct {logic [15:0] r; logic [4:0] s; logic e;} lr_t;
  exp_t sbq[$];
  lr_t pend[$];
  int errors = 0, checks = 0, cyc = 0, iss_tot = 0, ret_tot = 0, stall = 0, cnt = 0;
  int acc_cyc, n, i0, r0, a1;
  logic acc_ov, was_wait = 1'b0;
  logic [47:0] hold_ops;
  exp_t ea;
  always #5 clk_i = ~clk_i;
  fpnew_lane_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .in_operands_i(in_operands_i),
    .in_vectorial_i(in_vectorial_i), .in_mask_i(in_mask_i), .in_tag_i(in_tag_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .lane_operands_o(lane_operands_o),
    .lane_mask_o(lane_mask_o), .lane_valid_o(lane_valid_o), .lane_ready_i(lane_ready_i),
    .lane_flush_o(lane_flush_o), .lane_result_i(lane_result_i), .lane_status_i(lane_status_i),
    .lane_ext_bit_i(lane_ext_bit_i), .lane_valid_i(lane_valid_i), .lane_ready_o(lane_ready_o),
    .result_o(result_o), .status_o(status_o), .extension_bit_o(extension_bit_o), .tag_o(tag_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [191:0] ops, input logic vec, input logic [3:0] mask, input logic [0:0] tag);
    exp_t x;
    x.e = ops[128];
    x.s = '0;
    x.t = tag;
    x.r = '0;
    for (int k = 0; k < 4; k++)
      if (k == 0 || vec) begin
        x.r[k*16 +: 16] = ops[k*16 +: 16] + 16'h0400;
        if (mask[k]) x.s |= ops[64 + k*16 +: 5];
      end else x.r[k*16 +: 16] = {16{x.e}};
    return x;
  endfunction
  always @(posedge clk_i) cyc <= cyc + 1;
  // Lane unit: result = op0 + 0x0400, status = op1[4:0], ext = op2[0], one cycle later, in order.
  always @(posedge clk_i) begin
    if (!rst_ni || lane_flush_o) begin
      pend.delete();
      cnt = 0;
      lane_valid_i <= 1'b0;
      lane_ready_i <= stall == 0;
    end else begin
      if (lane_valid_i && lane_ready_o) begin
        void'(pend.pop_front());
        ret_tot++;
      end
      if (lane_valid_o && lane_ready_i) begin
        pend.push_back('{lane_operands_o[15:0] + 16'h0400, lane_operands_o[20:16], lane_operands_o[32]});
        iss_tot++;
        cnt = 0;
      end else if (lane_valid_o) cnt++;
      lane_ready_i <= stall == 0 || cnt >= stall;
      lane_valid_i <= pend.size() > 0;
      if (pend.size() > 0) begin
        lane_result_i  <= pend[0].r;
        lane_status_i  <= pend[0].s;
        lane_ext_bit_i <= pend[0].e;
      end
    end
  end
  always @(negedge clk_i) begin
    if (rst_ni && !flush_i && was_wait && lane_valid_o) chk("lane_hold", lane_operands_o, hold_ops);
    was_wait = rst_ni && lane_valid_o && !lane_ready_i;
    hold_ops = lane_operands_o;
  end
  always @(negedge clk_i)
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (sbq.size() == 0) chk("unexpected_out", out_valid_o, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", result_o, e.r);
        chk("status", status_o, e.s);
        chk("ext", extension_bit_o, e.e);
        chk("tag", tag_o, e.t);
      end
    end
  task automatic send(input logic [191:0] ops, input logic vec, input logic [3:0] mask, input logic [0:0] tag, input bit push);
    in_operands_i = ops;
    in_vectorial_i = vec;
    in_mask_i = mask;
    in_tag_i = tag;
    in_valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (in_ready_o) break;
    end
    chk("accept", in_ready_o, 1);
    acc_cyc = cyc;
    acc_ov = out_valid_o;
    if (push) sbq.push_back(model(ops, vec, mask, tag));
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
  endtask
  task automatic wait_out(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk_i);
      cycles++;
    end while (!out_valid_o && cycles < 200);
    chk("out_valid_timeout", out_valid_o, 1);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    in_operands_i = '0;
    in_vectorial_i = 1'b0;
    in_mask_i = '0;
    in_tag_i = '0;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_lane_valid", lane_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_status", status_o, 0);
    chk("rst_tag", tag_o, 0);
    chk("rst_ext", extension_bit_o, 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_in_ready", in_ready_o, 1);
    @(posedge clk_i);
    #1;
    i0 = iss_tot;
    send({64'h1, 64'h0, 64'h0000_0000_0000_3C00}, 1'b0, 4'b0001, 1'b1, 1);
    wait_out(n);
    chk("scalar_latency", n, 3);
    chk("scalar_result", result_o, 64'hFFFF_FFFF_FFFF_4000);
    @(posedge clk_i);
    #1 chk("scalar_issues", iss_tot - i0, 1);
    i0 = iss_tot;
    send({64'h0, 64'h0008_0004_0002_0001, 64'h4400_4200_4000_3C00}, 1'b1, 4'b0101, 1'b0, 1);
    wait_out(n);
    chk("vector_latency", n, 6);
    chk("vector_status", status_o, 5'b00101);
    chk("vector_result", result_o, 64'h4800_4600_4400_4000);
    @(posedge clk_i);
    #1 chk("vector_issues", iss_tot - i0, 4);
    stall = 3;
    i0 = iss_tot;
    r0 = ret_tot;
    send({64'h0, 64'h0010_0000_0008_0000, 64'h1111_2222_3333_4444}, 1'b1, 4'b1111, 1'b1, 1);
    wait_out(n);
    @(posedge clk_i);
    #1;
    chk("bp_issues", iss_tot - i0, 4);
    chk("bp_returns", ret_tot - r0, 4);
    stall = 0;
    out_ready_i = 1'b0;
    ea = model({64'h0, 64'h0003_0000_0000_0000, 64'h0100_0200_0300_0400}, 1'b1, 4'b1000, 1'b1);
    send({64'h0, 64'h0003_0000_0000_0000, 64'h0100_0200_0300_0400}, 1'b1, 4'b1000, 1'b1, 1);
    wait_out(n);
    repeat (5) begin
      @(negedge clk_i);
      chk("stall_result", result_o, ea.r);
      chk("stall_tag", tag_o, ea.t);
      chk("stall_in_ready", in_ready_o, 0);
      chk("stall_out_valid", out_valid_o, 1);
    end
    @(posedge clk_i);
    #1 out_ready_i = 1'b1;
    send({64'h1, 64'h0001_0001_0001_0001, 64'h0000_0000_0000_1000}, 1'b0, 4'b0001, 1'b0, 1);
    chk("stall_accept_in_done", acc_ov, 1);
    wait_out(n);
    @(posedge clk_i);
    #1;
    r0 = ret_tot;
    send({64'h0, 64'h001F_001F_001F_001F, 64'h5555_6666_7777_8888}, 1'b1, 4'b1111, 1'b1, 0);
    for (int i = 0; i < 100 && ret_tot - r0 != 2; i++) @(negedge clk_i);
    chk("flush_at_ret2", ret_tot - r0, 2);
    flush_i = 1'b1;
    #1 chk("lane_flush", lane_flush_o, 1);
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_busy", busy_o, 0);
    chk("flush_out_valid", out_valid_o, 0);
    @(posedge clk_i);
    #1;
    send({64'h0, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_2000}, 1'b0, 4'b0001, 1'b0, 1);
    wait_out(n);
    chk("clean_result", result_o, 64'h0000_0000_0000_2400);
    chk("clean_status", status_o, 5'b00010);
    @(posedge clk_i);
    #1;
    send({64'h0, 64'h0001_0002_0004_0008, 64'h0A00_0B00_0C00_0D00}, 1'b1, 4'b1100, 1'b0, 1);
    a1 = acc_cyc;
    send({64'h1, 64'h0010_0010_0001_0001, 64'h0E00_0F00_1000_1100}, 1'b1, 4'b0011, 1'b1, 1);
    chk("b2b_gap", acc_cyc - a1, 6);
    chk("b2b_accept_in_done", acc_ov, 1);
    wait_out(n);
    repeat (3) @(negedge clk_i);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
